// File: rtl/pixel_sequencer.sv
// Raster-order pixel sequencer: feeds coordinates to the raymarcher, packs finished pixels to RGB565
// and queues them for the framebuffer; 1-cycle push-to-write latency, stalls on fb_ready_in, drops when full.
module pixel_sequencer #(
  parameter int WIDTH      = 1280,
  parameter int HEIGHT     = 720,
  parameter int FIFO_DEPTH = 4,
  localparam int XW = $clog2(WIDTH),
  localparam int YW = $clog2(HEIGHT),
  localparam int AW = $clog2(WIDTH * HEIGHT)
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          pixel_done_in,
  input  logic [XW-1:0] px_x_in,
  input  logic [YW-1:0] px_y_in,
  input  logic [7:0]    red_in,
  input  logic [7:0]    green_in,
  input  logic [7:0]    blue_in,
  output logic [XW-1:0] curr_x_out,
  output logic [YW-1:0] curr_y_out,
  output logic [AW-1:0] fb_addr_out,
  output logic [15:0]   fb_data_out,
  output logic          fb_we_out,
  input  logic          fb_ready_in,
  output logic          frame_done_out,
  output logic [15:0]   frame_count_out,
  output logic          overflow_out
);

  localparam int IW = $clog2(FIFO_DEPTH);
  localparam int PW = IW + 1;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [15:0]   rgb;
    logic          last;
  } entry_t;

  entry_t        mem [FIFO_DEPTH];
  entry_t        entry_in;
  entry_t        head;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          first_flag;
  logic [AW-1:0] last_addr;
  logic [15:0]   last_data;
  logic          empty;
  logic          full;
  logic          valid_px;
  logic          pop;
  logic          push;
  logic          drop;
  logic          unused_colour_lsbs;

  assign unused_colour_lsbs = ^{red_in[2:0], green_in[1:0], blue_in[2:0]};

  assign entry_in.addr = AW'(px_y_in) * AW'(WIDTH) + AW'(px_x_in);
  assign entry_in.rgb  = {red_in[7:3], green_in[7:2], blue_in[7:3]};
  assign entry_in.last = (px_x_in == XW'(WIDTH - 1)) && (px_y_in == YW'(HEIGHT - 1));

  assign head  = mem[rd_ptr[IW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[IW] != rd_ptr[IW]) && (wr_ptr[IW-1:0] == rd_ptr[IW-1:0]);

  // The first pulse after reset carries no valid colour and is swallowed.
  assign valid_px = pixel_done_in && !first_flag;
  assign pop      = !empty && fb_ready_in;
  assign push     = valid_px && (!full || pop);
  assign drop     = valid_px && full && !pop;

  // With the queue empty the write port shows the last popped entry.
  assign fb_we_out   = !empty;
  assign fb_addr_out = empty ? last_addr : head.addr;
  assign fb_data_out = empty ? last_data : head.rgb;

  always_ff @(posedge clk_in) begin
    if (push) begin
      mem[wr_ptr[IW-1:0]] <= entry_in;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      first_flag      <= 1'b1;
      curr_x_out      <= '0;
      curr_y_out      <= '0;
      last_addr       <= '0;
      last_data       <= '0;
      frame_done_out  <= 1'b0;
      frame_count_out <= '0;
      overflow_out    <= 1'b0;
    end else begin
      if (pixel_done_in && first_flag) begin
        first_flag <= 1'b0;
      end

      // Coordinates advance even when the pixel itself is dropped.
      if (valid_px) begin
        if (curr_x_out == XW'(WIDTH - 1)) begin
          curr_x_out <= '0;
          if (curr_y_out == YW'(HEIGHT - 1)) begin
            curr_y_out <= '0;
          end else begin
            curr_y_out <= curr_y_out + 1'b1;
          end
        end else begin
          curr_x_out <= curr_x_out + 1'b1;
        end
      end

      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end

      if (pop) begin
        rd_ptr    <= rd_ptr + 1'b1;
        last_addr <= head.addr;
        last_data <= head.rgb;
      end

      frame_done_out <= pop && head.last;
      if (pop && head.last) begin
        frame_count_out <= frame_count_out + 16'd1;
      end

      if (drop) begin
        overflow_out <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pixel_sequencer.sv
// Directed bench for pixel_sequencer on a 4x2 raster with a 4-entry queue.
module tb_pixel_sequencer;

  logic        clk;
  logic        rst;
  logic        pixel_done;
  logic [1:0]  px_x;
  logic [0:0]  px_y;
  logic [7:0]  red;
  logic [7:0]  green;
  logic [7:0]  blue;
  logic [1:0]  curr_x;
  logic [0:0]  curr_y;
  logic [2:0]  fb_addr;
  logic [15:0] fb_data;
  logic        fb_we;
  logic        fb_ready;
  logic        frame_done;
  logic [15:0] frame_count;
  logic        overflow;

  int n_tests = 0;
  int n_fail  = 0;

  pixel_sequencer #(.WIDTH(4), .HEIGHT(2), .FIFO_DEPTH(4)) dut (
    .clk_in          (clk),
    .rst_in          (rst),
    .pixel_done_in   (pixel_done),
    .px_x_in         (px_x),
    .px_y_in         (px_y),
    .red_in          (red),
    .green_in        (green),
    .blue_in         (blue),
    .curr_x_out      (curr_x),
    .curr_y_out      (curr_y),
    .fb_addr_out     (fb_addr),
    .fb_data_out     (fb_data),
    .fb_we_out       (fb_we),
    .fb_ready_in     (fb_ready),
    .frame_done_out  (frame_done),
    .frame_count_out (frame_count),
    .overflow_out    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pix(input int x, input int y, input logic [7:0] r, input logic [7:0] g,
                     input logic [7:0] b);
    pixel_done = 1'b1;
    px_x       = x[1:0];
    px_y       = y[0:0];
    red        = r;
    green      = g;
    blue       = b;
    step();
    pixel_done = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    pixel_done = 1'b0;
    px_x       = '0;
    px_y       = '0;
    red        = '0;
    green      = '0;
    blue       = '0;
    fb_ready   = 1'b0;
    step();
    step();

    chk("rst_curr_x", 32'(curr_x), 0);
    chk("rst_curr_y", 32'(curr_y), 0);
    chk("rst_we", 32'(fb_we), 0);
    chk("rst_addr", 32'(fb_addr), 0);
    chk("rst_data", 32'(fb_data), 0);
    chk("rst_frame_done", 32'(frame_done), 0);
    chk("rst_frame_count", 32'(frame_count), 0);
    chk("rst_overflow", 32'(overflow), 0);

    rst = 1'b0;
    step();                                     // cycle 0
    pix(0, 0, 8'h00, 8'h00, 8'h00);             // cycle 1: discarded
    chk("discard_curr_x", 32'(curr_x), 0);
    chk("discard_we", 32'(fb_we), 0);
    step(); step(); step();                     // cycles 2..4
    chk("we_cycle5", 32'(fb_we), 0);
    pix(0, 0, 8'h08, 8'h04, 8'h08);             // cycle 5
    chk("c6_curr_x", 32'(curr_x), 1);
    chk("c6_curr_y", 32'(curr_y), 0);
    chk("c6_we", 32'(fb_we), 1);
    chk("c6_addr", 32'(fb_addr), 0);
    chk("c6_data", 32'(fb_data), 32'h0821);
    step(); step(); step();
    pix(1, 0, 8'hFF, 8'hFF, 8'hFF);             // cycle 9
    chk("c10_curr_x", 32'(curr_x), 2);
    step(); step(); step();
    pix(2, 0, 8'h00, 8'h00, 8'h00);             // cycle 13
    chk("c14_curr_x", 32'(curr_x), 3);
    chk("c14_curr_y", 32'(curr_y), 0);
    chk("stall_addr", 32'(fb_addr), 0);
    chk("stall_data", 32'(fb_data), 32'h0821);

    fb_ready = 1'b1;
    step();
    chk("drain1_addr", 32'(fb_addr), 1);
    chk("drain1_data", 32'(fb_data), 32'hFFFF);
    step();
    chk("drain2_addr", 32'(fb_addr), 2);
    step();
    chk("drain_empty_we", 32'(fb_we), 0);
    chk("drain_hold_addr", 32'(fb_addr), 2);
    fb_ready = 1'b0;

    // Three queued entries, curr=(2,1), then a one-cycle reset.
    pix(3, 0, 8'h11, 8'h22, 8'h33);
    pix(0, 1, 8'h11, 8'h22, 8'h33);
    pix(1, 1, 8'h11, 8'h22, 8'h33);
    chk("pre_rst_curr_x", 32'(curr_x), 2);
    chk("pre_rst_curr_y", 32'(curr_y), 1);
    chk("pre_rst_addr", 32'(fb_addr), 3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_we", 32'(fb_we), 0);
    chk("midrst_curr_x", 32'(curr_x), 0);
    chk("midrst_curr_y", 32'(curr_y), 0);
    pix(0, 0, 8'hFF, 8'hFF, 8'hFF);
    chk("midrst_discard_curr_x", 32'(curr_x), 0);
    chk("midrst_discard_we", 32'(fb_we), 0);

    // Full 4x2 frame with the framebuffer always ready.
    fb_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i == 7) pix(3, 1, 8'hFF, 8'h80, 8'h1F);
      else        pix(i % 4, i / 4, 8'h00, 8'h00, 8'h00);
      chk($sformatf("frame_addr%0d", i), 32'(fb_addr), i);
      chk($sformatf("frame_we%0d", i), 32'(fb_we), 1);
      chk($sformatf("frame_done_early%0d", i), 32'(frame_done), 0);
      chk($sformatf("frame_curr_x%0d", i), 32'(curr_x), (i + 1) % 4);
      chk($sformatf("frame_curr_y%0d", i), 32'(curr_y), ((i + 1) / 4) % 2);
    end
    chk("pack_data", 32'(fb_data), 32'hFC03);
    pixel_done = 1'b0;
    step();
    chk("frame_done_pulse", 32'(frame_done), 1);
    chk("frame_count_1", 32'(frame_count), 1);
    chk("frame_we_end", 32'(fb_we), 0);
    step();
    chk("frame_done_clear", 32'(frame_done), 0);
    chk("frame_count_hold", 32'(frame_count), 1);
    fb_ready = 1'b0;

    // Backpressure: fill, overflow on a fifth push, then drain.
    pix(0, 0, 8'hF8, 8'h00, 8'h00);
    chk("bp_first_addr", 32'(fb_addr), 0);
    chk("bp_first_data", 32'(fb_data), 32'hF800);
    pix(1, 0, 8'h00, 8'hFC, 8'h00);
    pix(2, 0, 8'h00, 8'h00, 8'hF8);
    pix(3, 0, 8'hFF, 8'hFF, 8'hFF);
    chk("bp_full_no_ovf", 32'(overflow), 0);
    chk("bp_full_addr", 32'(fb_addr), 0);
    step();
    chk("bp_idle_addr", 32'(fb_addr), 0);
    chk("bp_idle_data", 32'(fb_data), 32'hF800);
    pix(0, 1, 8'h12, 8'h34, 8'h56);
    chk("bp_ovf", 32'(overflow), 1);
    chk("bp_ovf_curr_x", 32'(curr_x), 1);
    chk("bp_ovf_curr_y", 32'(curr_y), 1);
    chk("bp_ovf_addr", 32'(fb_addr), 0);
    fb_ready = 1'b1;
    step();
    chk("bp_w1_addr", 32'(fb_addr), 1);
    chk("bp_w1_data", 32'(fb_data), 32'h07E0);
    step();
    chk("bp_w2_addr", 32'(fb_addr), 2);
    chk("bp_w2_data", 32'(fb_data), 32'h001F);
    step();
    chk("bp_w3_addr", 32'(fb_addr), 3);
    chk("bp_w3_data", 32'(fb_data), 32'hFFFF);
    step();
    chk("bp_empty_we", 32'(fb_we), 0);
    chk("bp_hold_addr", 32'(fb_addr), 3);
    chk("bp_hold_data", 32'(fb_data), 32'hFFFF);
    chk("bp_ovf_sticky", 32'(overflow), 1);
    fb_ready = 1'b0;

    // Full queue with simultaneous push and pop.
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst2_ovf", 32'(overflow), 0);
    chk("rst2_count", 32'(frame_count), 0);
    pix(0, 0, 8'h00, 8'h00, 8'h00);
    pix(0, 0, 8'h00, 8'h00, 8'h00);
    pix(1, 0, 8'h00, 8'h00, 8'h00);
    pix(2, 0, 8'h00, 8'h00, 8'h00);
    pix(0, 1, 8'h00, 8'h00, 8'h00);
    chk("pp_full_ovf", 32'(overflow), 0);
    chk("pp_full_addr", 32'(fb_addr), 0);
    fb_ready = 1'b1;
    pix(1, 1, 8'h00, 8'h00, 8'h00);
    fb_ready = 1'b0;
    chk("pp_no_ovf", 32'(overflow), 0);
    chk("pp_we", 32'(fb_we), 1);
    chk("pp_addr", 32'(fb_addr), 1);
    pix(2, 1, 8'h00, 8'h00, 8'h00);
    chk("pp_still_full", 32'(overflow), 1);
    fb_ready = 1'b1;
    step();
    chk("pp_w1_addr", 32'(fb_addr), 2);
    step();
    chk("pp_w2_addr", 32'(fb_addr), 4);
    step();
    chk("pp_w3_addr", 32'(fb_addr), 5);
    step();
    chk("pp_empty_we", 32'(fb_we), 0);
    fb_ready = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
